alu_seq_ctrl: RTL and testbench

- Issue/sequencing controller in front of the top-level ALU wrapper.
- Accepts one ALU operation at a time over a valid/ready handshake and registers the operands.
- Drives the ALU enable, type, width, immediate and operand inputs for the op's latency (single- or multi-cycle), then captures the ALU result and presents it on a valid/ready output.
- Sits between the decode/issue stage and writeback; its `busy` output is the pipeline stall source.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_lat_decode.sv | 29 ++
 rtl/alu_seq_ctrl.sv | 111 +++++++++++
 tb/tb_alu_seq_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared aluType codes, sequencer states and latency classes
package alu_pkg;

  // aluType codes that select a multicycle latency class
  localparam logic [5:0] TYPE_MUL_A = 6'b000101;
  localparam logic [5:0] TYPE_MUL_B = 6'b000110;
  localparam logic [5:0] TYPE_DIV_A = 6'b000111;
  localparam logic [5:0] TYPE_DIV_B = 6'b001000;

  // Element width code for double-word operation
  localparam logic [1:0] WW_DOUBLE = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } seqState_t;

  typedef enum logic [1:0] {
    LAT_SINGLE = 2'b00,
    LAT_MULT   = 2'b01,
    LAT_DIV    = 2'b10
  } latClass_t;

  function automatic logic isMultiClass(latClass_t latClass);
    return latClass != LAT_SINGLE;
  endfunction

endpackage

// File: rtl/alu_lat_decode.sv
// rtl/alu_lat_decode.sv - aluType/ww to latency class and hold-cycle count
module alu_lat_decode
  import alu_pkg::*;
#(
  parameter int MULT_LAT   = 4,
  parameter int DIV_LAT    = 8,
  parameter int SINGLE_LAT = 1,
  parameter int CNT_W      = 4
) (
  input  logic [5:0]       aluType,
  input  logic [1:0]       ww,
  output latClass_t        latClass,
  output logic [CNT_W-1:0] lat
);

  // Multiply is only multicycle at double width; divide always is
  always_comb begin
    latClass = LAT_SINGLE;
    lat      = CNT_W'(SINGLE_LAT);
    if ((aluType == TYPE_MUL_A || aluType == TYPE_MUL_B) && ww == WW_DOUBLE) begin
      latClass = LAT_MULT;
      lat      = CNT_W'(MULT_LAT);
    end else if (aluType == TYPE_DIV_A || aluType == TYPE_DIV_B) begin
      latClass = LAT_DIV;
      lat      = CNT_W'(DIV_LAT);
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - issue/sequencing controller holding one op on the ALU
// Operand vectors keep the codebase's bit-0-is-MSB meaning: vector MSB is bit 0.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int MULT_LAT   = 4,
  parameter int DIV_LAT    = 8,
  parameter int SINGLE_LAT = 1,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_type,
  input  logic [1:0]  in_ww,
  input  logic [4:0]  in_imm,
  input  logic [63:0] in_oprA,
  input  logic [63:0] in_oprB,
  input  logic        flush,
  output logic        alu_en,
  output logic [5:0]  alu_type,
  output logic [1:0]  alu_ww,
  output logic [4:0]  alu_imm,
  output logic [63:0] alu_oprA,
  output logic [63:0] alu_oprB,
  input  logic [63:0] alu_dout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy,
  output logic        is_multi
);

  seqState_t        state;
  logic [CNT_W-1:0] cnt;
  latClass_t        decClass;
  logic [CNT_W-1:0] decLat;
  logic             acceptOp;

  alu_lat_decode #(
    .MULT_LAT  (MULT_LAT),
    .DIV_LAT   (DIV_LAT),
    .SINGLE_LAT(SINGLE_LAT),
    .CNT_W     (CNT_W)
  ) u_lat_decode (
    .aluType (in_type),
    .ww      (in_ww),
    .latClass(decClass),
    .lat     (decLat)
  );

  // A finished result frees the slot in the same cycle the consumer takes it
  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign busy     = ~in_ready;
  assign acceptOp = in_valid && in_ready && !flush;

  // Sequencer: accept latches the op, EXEC counts down, DONE presents the result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      alu_en    <= 1'b0;
      alu_type  <= '0;
      alu_ww    <= '0;
      alu_imm   <= '0;
      alu_oprA  <= '0;
      alu_oprB  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      is_multi  <= 1'b0;
    end else if (acceptOp) begin
      alu_type  <= in_type;
      alu_ww    <= in_ww;
      alu_imm   <= in_imm;
      alu_oprA  <= in_oprA;
      alu_oprB  <= in_oprB;
      cnt       <= decLat - CNT_W'(1);
      is_multi  <= isMultiClass(decClass);
      alu_en    <= 1'b1;
      out_valid <= 1'b0;
      state     <= EXEC;
    end else begin
      case (state)
        EXEC: begin
          if (flush) begin
            alu_en   <= 1'b0;
            is_multi <= 1'b0;
            state    <= IDLE;
          end else if (cnt == '0) begin
            out_data  <= alu_dout;
            out_valid <= 1'b1;
            alu_en    <= 1'b0;
            state     <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          if (flush || out_ready) begin
            out_valid <= 1'b0;
            is_multi  <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - scoreboard bench for alu_seq_ctrl with a stub ALU
module tb_alu_seq_ctrl;

  localparam int MULT_LAT   = 4;
  localparam int DIV_LAT    = 8;
  localparam int SINGLE_LAT = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_type;
  logic [1:0]  in_ww;
  logic [4:0]  in_imm;
  logic [63:0] in_oprA;
  logic [63:0] in_oprB;
  logic        flush;
  logic        alu_en;
  logic [5:0]  alu_type;
  logic [1:0]  alu_ww;
  logic [4:0]  alu_imm;
  logic [63:0] alu_oprA;
  logic [63:0] alu_oprB;
  logic [63:0] alu_dout;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        busy;
  logic        is_multi;

  typedef struct {
    logic [63:0] data;
    logic [63:0] a;
    logic [63:0] b;
    logic [5:0]  t;
    logic [1:0]  w;
    logic [4:0]  imm;
    int          acc;
    int          due;
    logic        multi;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   nChecks = 0;
  int   nPass = 0;
  bit   started = 0;

  alu_seq_ctrl #(
    .MULT_LAT  (MULT_LAT),
    .DIV_LAT   (DIV_LAT),
    .SINGLE_LAT(SINGLE_LAT),
    .CNT_W     (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_type  (in_type),
    .in_ww    (in_ww),
    .in_imm   (in_imm),
    .in_oprA  (in_oprA),
    .in_oprB  (in_oprB),
    .flush    (flush),
    .alu_en   (alu_en),
    .alu_type (alu_type),
    .alu_ww   (alu_ww),
    .alu_imm  (alu_imm),
    .alu_oprA (alu_oprA),
    .alu_oprB (alu_oprB),
    .alu_dout (alu_dout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy),
    .is_multi (is_multi)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub ALU: any function of all control/operand inputs
  function automatic logic [63:0] aluModel(logic [5:0] t, logic [1:0] w, logic [4:0] imm,
                                           logic [63:0] a, logic [63:0] b);
    return (a + b) ^ {b[31:0], a[63:32]} ^ {51'b0, t, w, imm};
  endfunction

  assign alu_dout = aluModel(alu_type, alu_ww, alu_imm, alu_oprA, alu_oprB);

  function automatic bit isMul(logic [5:0] t, logic [1:0] w);
    return (t == 6'd5 || t == 6'd6) && w == 2'b11;
  endfunction

  function automatic bit isDiv(logic [5:0] t);
    return t == 6'd7 || t == 6'd8;
  endfunction

  function automatic int latOf(logic [5:0] t, logic [1:0] w);
    if (isMul(t, w)) return MULT_LAT;
    if (isDiv(t)) return DIV_LAT;
    return SINGLE_LAT;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Compares DUT outputs each cycle against the oldest outstanding op
  task automatic monitorStep();
    bit inFlight, shown, expReady;
    inFlight = q.size() > 0 && q[0].acc < cyc;
    shown    = inFlight && cyc >= q[0].due;
    expReady = !inFlight || (shown && out_ready);
    chk("alu_en", alu_en, inFlight && !shown);
    if (inFlight && !shown) begin
      chk("alu_oprA", alu_oprA, q[0].a);
      chk("alu_oprB", alu_oprB, q[0].b);
      chk("alu_ctrl", {alu_type, alu_ww, alu_imm}, {q[0].t, q[0].w, q[0].imm});
    end
    chk("out_valid", out_valid, shown);
    if (shown) chk("out_data", out_data, q[0].data);
    if (inFlight) chk("is_multi", is_multi, q[0].multi);
    chk("in_ready", in_ready, expReady);
    chk("busy", busy, !expReady);
    if (inFlight && flush) void'(q.pop_front());
    else if (shown && out_ready) void'(q.pop_front());
  endtask

  always @(negedge clk) begin
    #2;
    if (started && !reset) monitorStep();
  end

  // One cycle of stimulus; records the expected result when the op is taken
  task automatic step(bit v, logic [5:0] t, logic [1:0] w, logic [4:0] imm,
                      logic [63:0] a, logic [63:0] b, bit ordy, bit fl);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    in_type   = t;
    in_ww     = w;
    in_imm    = imm;
    in_oprA   = a;
    in_oprB   = b;
    out_ready = ordy;
    flush     = fl;
    #1;
    if (v && in_ready && !fl) begin
      e.data  = aluModel(t, w, imm, a, b);
      e.a     = a;
      e.b     = b;
      e.t     = t;
      e.w     = w;
      e.imm   = imm;
      e.acc   = cyc;
      e.due   = cyc + latOf(t, w) + 1;
      e.multi = isMul(t, w) || isDiv(t);
      q.push_back(e);
    end
  endtask

  task automatic idle(int n, bit ordy);
    for (int i = 0; i < n; i++) step(0, 6'd0, 2'd0, 5'd0, 64'd0, 64'd0, ordy, 0);
  endtask

  initial begin
    logic [5:0] t;
    int         k;
    reset = 1'b1;
    in_valid = 0; in_type = 0; in_ww = 0; in_imm = 0; in_oprA = 0; in_oprB = 0;
    flush = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_alu_en", alu_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_is_multi", is_multi, 0);
    chk("rst_alu_oprA", alu_oprA, 0);
    chk("rst_in_ready", in_ready, 1);
    reset = 1'b0;
    started = 1;

    // Single-cycle op held for consumer, then released
    step(1, 6'd0, 2'd0, 5'd0, 64'd5, 64'd3, 0, 0);
    idle(4, 0);
    idle(2, 1);
    // Double-width multiply, then same type at narrower width
    step(1, 6'd5, 2'd3, 5'd7, 64'h1234_5678_9abc_def0, 64'h0fed_cba9_8765_4321, 1, 0);
    idle(MULT_LAT + 2, 1);
    step(1, 6'd5, 2'd2, 5'd1, 64'd77, 64'd99, 1, 0);
    idle(3, 1);
    // Divide with consumer stalling past completion
    step(1, 6'd8, 2'd0, 5'd2, 64'hffff_0000_ffff_0000, 64'd17, 0, 0);
    idle(DIV_LAT + 4, 0);
    idle(2, 1);
    // Back-to-back: new op offered in the DONE cycle
    step(1, 6'd6, 2'd3, 5'd3, 64'd1000, 64'd2000, 0, 0);
    idle(MULT_LAT, 0);
    step(1, 6'd1, 2'd1, 5'd4, 64'd11, 64'd22, 1, 0);
    idle(3, 1);
    // Flush in the second EXEC cycle of a divide
    step(1, 6'd7, 2'd0, 5'd0, 64'd123, 64'd456, 0, 0);
    idle(1, 0);
    step(0, 6'd0, 2'd0, 5'd0, 64'd0, 64'd0, 0, 1);
    idle(DIV_LAT + 3, 1);
    // Flush coinciding with a new offer in DONE
    step(1, 6'd2, 2'd0, 5'd0, 64'd9, 64'd8, 0, 0);
    idle(1, 0);
    step(1, 6'd5, 2'd3, 5'd0, 64'd3, 64'd4, 1, 1);
    idle(3, 1);
    // Async reset between clock edges in the middle of EXEC
    step(1, 6'd7, 2'd0, 5'd0, 64'd55, 64'd66, 0, 0);
    idle(2, 0);
    @(negedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_alu_en", alu_en, 0);
    chk("arst_is_multi", is_multi, 0);
    chk("arst_alu_oprA", alu_oprA, 0);
    chk("arst_out_valid", out_valid, 0);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    #3;
    reset = 1'b0;
    step(1, 6'd3, 2'd1, 5'd9, 64'd31, 64'd41, 1, 0);
    idle(3, 1);

    // Randomized traffic biased toward the multicycle codes
    for (int i = 0; i < 500; i++) begin
      k = $urandom_range(0, 5);
      case (k)
        0: t = 6'd0;
        1: t = 6'd5;
        2: t = 6'd6;
        3: t = 6'd7;
        4: t = 6'd8;
        default: t = 6'($urandom_range(0, 63));
      endcase
      step(bit'($urandom_range(0, 1)), t, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
           {$urandom, $urandom}, {$urandom, $urandom}, ($urandom % 4) != 0, ($urandom % 20) == 0);
    end

    for (int i = 0; i < 30 && q.size() > 0; i++) idle(1, 1);
    chk("drain", q.size(), 0);
    @(negedge clk);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
